// File: rtl/reg_access_arb.sv
// reg_access_arb: round-robin arbiter that serializes requester register accesses onto one register port with ack timeout.
// Ports: clk/rst (async active-high); req/req_write/req_addr/req_wdata packed per requester;
// gnt/done/rsp_rdata/rsp_err back to requesters; reg_read/reg_write/reg_addr/reg_wdata/reg_ack/reg_rdata
// on the register side; err_flag/alert_line from the error detector; busy/timeout_err/timeout_count status.
module reg_access_arb #(
  parameter int NUM_REQ = 4,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  done,
  output logic [REG_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                rsp_err,
  output logic                                reg_read,
  output logic                                reg_write,
  output logic [REG_ADDR_WIDTH-1:0]           reg_addr,
  output logic [REG_DATA_WIDTH-1:0]           reg_wdata,
  input  logic                                reg_ack,
  input  logic [REG_DATA_WIDTH-1:0]           reg_rdata,
  input  logic                                err_flag,
  input  logic                                alert_line,
  output logic                                busy,
  output logic                                timeout_err,
  output logic [15:0]                         timeout_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int IW1 = IW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d;
  logic write_q, write_d, err_q, err_d, to_q, to_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0] elig, rot;
  logic [2*NUM_REQ-1:0] dbl;
  logic [IW-1:0] off, win;
  logic [IW:0] sum;
  logic win_wr;
  logic [REG_ADDR_WIDTH-1:0] win_addr;
  logic [REG_DATA_WIDTH-1:0] win_wdata;
  // Rotate eligible requests so bit 0 is rr_q; the lowest set bit is the winner's offset from rr_q.
  always_comb begin
    elig = alert_line ? (req & NUM_REQ'(1)) : req;
    dbl = {elig, elig} >> rr_q;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, rr_q} + {1'b0, off};
    win = (sum >= IW1'(NUM_REQ)) ? IW'(sum - IW1'(NUM_REQ)) : IW'(sum);
    win_wr = 1'b0;
    win_addr = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win == IW'(k)) begin
        win_wr = req_write[k];
        win_addr = req_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        win_wdata = req_wdata[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      owner_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      err_q <= err_d;
      to_q <= to_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
    end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    write_d = write_q;
    err_d = err_q;
    to_d = to_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    tcnt_d = tcnt_q;
    unique case (state_q)
      IDLE: if (|elig) begin
        state_d = ISSUE;
        owner_d = win;
        write_d = win_wr;
        addr_d = win_addr;
        wdata_d = win_wdata;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = 8'd1;
      end
      WAIT: if (reg_ack) begin
        state_d = DONE;
        rdata_d = reg_rdata;
        err_d = err_flag;
        to_d = 1'b0;
      end else if (cnt_q == 8'(TIMEOUT)) begin
        state_d = DONE;
        rdata_d = '0;
        err_d = 1'b1;
        to_d = 1'b1;
        tcnt_d = &tcnt_q ? tcnt_q : tcnt_q + 16'd1;
      end else cnt_d = cnt_q + 8'd1;
      DONE: begin
        state_d = IDLE;
        rr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    gnt = busy ? NUM_REQ'(1) << owner_q : '0;
    done = (state_q == DONE) ? NUM_REQ'(1) << owner_q : '0;
    reg_read = state_q == ISSUE && !write_q;
    reg_write = state_q == ISSUE && write_q;
    timeout_err = state_q == DONE && to_q;
    reg_addr = addr_q;
    reg_wdata = wdata_q;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
    timeout_count = tcnt_q;
  end
endmodule

// File: tb/tb_reg_access_arb.sv
// tb_reg_access_arb: directed table-driven bench for reg_access_arb plus alert and reset sequences.
module tb_reg_access_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, req_write = '0, gnt, done;
  logic [31:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [31:0] rsp_rdata, reg_wdata, reg_rdata = '0;
  logic rsp_err, reg_read, reg_write, reg_ack = 1'b0, err_flag = 1'b0, alert_line = 1'b0;
  logic busy, timeout_err;
  logic [7:0] reg_addr;
  logic [15:0] timeout_count;
  int errors = 0, checks = 0;
  reg_access_arb dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .err_flag(err_flag), .alert_line(alert_line),
    .busy(busy), .timeout_err(timeout_err), .timeout_count(timeout_count)
  );
  always #5 clk = ~clk;
  localparam logic [31:0] A = 32'h43424140;
  localparam logic [127:0] D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
  typedef struct {
    logic [3:0] req, wr;
    logic [31:0] addr;
    logic [127:0] wdata;
    logic [31:0] rdata;
    logic err;
    int ack_at;
    logic ack_issue;
    logic [3:0] gnt;
    logic [1:0] strobe;
    logic [7:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    logic e_err, e_to;
    logic [15:0] e_tc;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic zeros(input string nm);
    chk(nm, {gnt, done, busy, reg_read, reg_write, timeout_err, rsp_err, rsp_rdata, reg_addr, reg_wdata, timeout_count}, '0);
  endtask
  task automatic wait_gnt(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 0 && k < 20);
  endtask
  task automatic wait_done(input int ack_at, input logic ai, output int w);
    reg_ack = ai;
    @(negedge clk);
    chk("strobe_one_cycle", {reg_write, reg_read}, 2'b00);
    w = 0;
    do begin
      reg_ack = (w + 1 == ack_at);
      @(negedge clk);
      w++;
    end while (done == 0 && w < 40);
    reg_ack = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input int n);
    int k, w;
    req = v.req; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    reg_rdata = v.rdata; err_flag = v.err;
    wait_gnt(k);
    chk($sformatf("v%0d_gnt", n), gnt, v.gnt);
    chk($sformatf("v%0d_gnt_latency", n), k, 1);
    chk($sformatf("v%0d_strobe", n), {reg_write, reg_read}, v.strobe);
    chk($sformatf("v%0d_addr", n), reg_addr, v.e_addr);
    chk($sformatf("v%0d_wdata", n), reg_wdata, v.e_wdata);
    wait_done(v.ack_at, v.ack_issue, w);
    chk($sformatf("v%0d_wait_cycles", n), w, v.ack_at > 0 ? v.ack_at : 15);
    chk($sformatf("v%0d_done", n), done, v.gnt);
    chk($sformatf("v%0d_gnt_in_done", n), gnt, v.gnt);
    chk($sformatf("v%0d_rdata", n), rsp_rdata, v.e_rdata);
    chk($sformatf("v%0d_err", n), rsp_err, v.e_err);
    chk($sformatf("v%0d_timeout_err", n), timeout_err, v.e_to);
    chk($sformatf("v%0d_timeout_count", n), timeout_count, v.e_tc);
    chk($sformatf("v%0d_held", n), {reg_addr, reg_wdata}, {v.e_addr, v.e_wdata});
    reg_ack = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_after_done", n), {gnt, done, busy, timeout_err}, '0);
    reg_ack = 1'b0;
  endtask
  initial begin
    int k, w;
    tbl[0]  = '{4'hF, 4'h4, A, D, 32'h100, 1'b0, 1, 1'b0, 4'h1, 2'b01, 8'h40, 32'hD0D0D0D0, 32'h100, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{4'hF, 4'h4, A, D, 32'h101, 1'b0, 1, 1'b0, 4'h2, 2'b01, 8'h41, 32'hD1D1D1D1, 32'h101, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{4'hF, 4'h4, A, D, 32'h102, 1'b0, 1, 1'b0, 4'h4, 2'b10, 8'h42, 32'hD2D2D2D2, 32'h102, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{4'hF, 4'h4, A, D, 32'h103, 1'b0, 1, 1'b0, 4'h8, 2'b01, 8'h43, 32'hD3D3D3D3, 32'h103, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{4'hF, 4'h4, A, D, 32'h104, 1'b0, 1, 1'b0, 4'h1, 2'b01, 8'h40, 32'hD0D0D0D0, 32'h104, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{4'h4, 4'h4, 32'h433C4140, {32'hD3D3D3D3, 32'hDEADBEEF, 32'hD1D1D1D1, 32'hD0D0D0D0},
                32'hCAFEF00D, 1'b0, 3, 1'b1, 4'h4, 2'b10, 8'h3C, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{4'h2, 4'h0, A, D, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 4'h2, 2'b01, 8'h41, 32'hD1D1D1D1, 32'h0, 1'b1, 1'b1, 16'd1};
    tbl[7]  = '{4'h8, 4'h0, A, D, 32'h5A5A5A5A, 1'b1, 2, 1'b0, 4'h8, 2'b01, 8'h43, 32'hD3D3D3D3, 32'h5A5A5A5A, 1'b1, 1'b0, 16'd1};
    tbl[8]  = '{4'hA, 4'h0, A, D, 32'h12345678, 1'b0, 1, 1'b0, 4'h2, 2'b01, 8'h41, 32'hD1D1D1D1, 32'h12345678, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{4'hA, 4'h8, A, D, 32'h0BADC0DE, 1'b0, 1, 1'b0, 4'h8, 2'b10, 8'h43, 32'hD3D3D3D3, 32'h0BADC0DE, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{4'h1, 4'h0, A, D, 32'h00000077, 1'b0, 15, 1'b0, 4'h1, 2'b01, 8'h40, 32'hD0D0D0D0, 32'h77, 1'b0, 1'b0, 16'd1};
    repeat (3) @(negedge clk);
    zeros("reset_outputs");
    rst = 1'b0;
    reg_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_ignored", {busy, done}, '0);
    reg_ack = 1'b0;
    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);
    alert_line = 1'b1;
    req = 4'b0110;
    k = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != 0 || busy) k++;
    end
    chk("alert_blocks", k, 0);
    req = 4'b0111;
    wait_gnt(k);
    chk("alert_gnt0", gnt, 4'b0001);
    req = 4'b0110;
    alert_line = 1'b0;
    reg_rdata = 32'h0000000A;
    err_flag = 1'b0;
    wait_done(2, 1'b0, w);
    chk("drop_req_done0", done, 4'b0001);
    chk("drop_req_rdata", rsp_rdata, 32'h0A);
    wait_gnt(k);
    chk("after_alert_gnt1", gnt, 4'b0010);
    chk("back_to_back_gap", k, 2);
    wait_done(1, 1'b0, w);
    chk("after_alert_done1", done, 4'b0010);
    req = 4'b1000;
    wait_gnt(k);
    chk("pre_reset_gnt3", gnt, 4'b1000);
    repeat (2) @(negedge clk);
    chk("pre_reset_waiting", {busy, done}, {1'b1, 4'b0000});
    #2 rst = 1'b1;
    #1 zeros("async_reset_outputs");
    @(negedge clk);
    zeros("reset_held_outputs");
    rst = 1'b0;
    req = 4'b1001;
    wait_gnt(k);
    chk("post_reset_gnt0", gnt, 4'b0001);
    chk("post_reset_no_done", done, 4'b0000);
    wait_done(1, 1'b0, w);
    chk("post_reset_done0", done, 4'b0001);
    req = '0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
